jtag_ahb_master: RTL and testbench

- AHB-Lite single-transfer bus master that executes debug commands produced by the JTAG TAP controller (address-set, write, read).
- Sits directly downstream of the jtag block: consumes the address/data values latched via the IR=0010 (address) and IR=0011 (write data) data registers, and owns the HREADY handshake that jtag samples.
- The command interface is in the HCLK domain; TCK-to-HCLK crossing is done in jtag's Update-DR synchroniser.

---
 rtl/jtag_ahb_master.sv | 117 +++++++++++
 tb/tb_jtag_ahb_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_ahb_master.sv
// AHB-Lite single-transfer master that runs JTAG debug commands (set address, write, read).
// Every bus and response output is registered, and only one transfer is ever outstanding.
module jtag_ahb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   haddr_q;
    logic [1:0]              htrans_q;
    logic                    hwrite_q;
    logic [DATA_WIDTH-1:0]   hwdata_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_err_q;
    logic [ADDR_WIDTH-1:0]   addr_inc_d;

    // Wraps modulo 2^ADDR_WIDTH by construction.
    assign addr_inc_d = addr_q + ADDR_WIDTH'(DATA_WIDTH / 8);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            haddr_q     <= '0;
            htrans_q    <= 2'b00;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    case (cmd_op)
                        2'b00: begin
                            addr_q      <= ADDR_WIDTH'(cmd_data);
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= cmd_data;
                            rsp_err_q   <= 1'b0;
                            state_q     <= RESP;
                        end
                        2'b11: begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            state_q     <= RESP;
                        end
                        default: begin
                            wdata_q  <= cmd_data;
                            haddr_q  <= {addr_q[ADDR_WIDTH-1:2], 2'b00};
                            htrans_q <= 2'b10;
                            hwrite_q <= (cmd_op == 2'b01);
                            state_q  <= ADDR;
                        end
                    endcase
                end
                ADDR: if (HREADY) begin
                    htrans_q <= 2'b00;
                    hwdata_q <= hwrite_q ? wdata_q : '0;
                    state_q  <= DATA;
                end
                DATA: if (HREADY) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= HRESP;
                    rsp_data_q  <= hwrite_q ? '0 : HRDATA;
                    if (AUTO_INC && !HRESP)
                        addr_q <= addr_inc_d;
                    state_q <= RESP;
                end
                default: begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE) && !HRESET;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_jtag_ahb_master.sv
// Directed bench for jtag_ahb_master: address set, write, waited read, error, wrap,
// reserved op, command backpressure and reset mid-transfer.
module tb_jtag_ahb_master;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    jtag_ahb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .AUTO_INC(1'b1)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Present one command for a single edge; the DUT must be ready for it.
    task automatic send(input logic [1:0] op, input logic [31:0] data);
        chk("ready_before_send", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
    endtask

    // Zero-wait read from current address; checks HADDR and returned data.
    task automatic read_ok(input string tag, input logic [31:0] exp_addr, input logic [31:0] rdata);
        HREADY = 1'b1;
        HRDATA = rdata;
        send(2'b10, 32'h0);
        chk({tag, "_haddr"}, HADDR, exp_addr);
        chk({tag, "_htrans"}, HTRANS, 2'b10);
        step();
        step();
        chk({tag, "_rvalid"}, rsp_valid, 1);
        chk({tag, "_rdata"}, rsp_data, rdata);
        step();
    endtask

    logic hr_sched [1:7];
    int   nonseq;

    initial begin
        // reset state
        step();
        step();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_hsize", HSIZE, 3'b010);
        chk("rst_hburst", HBURST, 3'b000);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
        HRESET = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1);

        // set address then zero-wait write
        send(2'b00, 32'h2000_0010);
        chk("seta_rvalid", rsp_valid, 1);
        chk("seta_rdata", rsp_data, 32'h2000_0010);
        chk("seta_err", rsp_err, 0);
        chk("seta_htrans", HTRANS, 2'b00);
        step();
        chk("seta_pulse_end", rsp_valid, 0);
        send(2'b01, 32'hDEAD_BEEF);
        chk("wr_htrans", HTRANS, 2'b10);
        chk("wr_haddr", HADDR, 32'h2000_0010);
        chk("wr_hwrite", HWRITE, 1);
        chk("wr_busy", cmd_ready, 0);
        step();
        chk("wr_data_htrans", HTRANS, 2'b00);
        chk("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
        chk("wr_no_rsp_yet", rsp_valid, 0);
        step();
        chk("wr_rvalid", rsp_valid, 1);
        chk("wr_err", rsp_err, 0);
        chk("wr_rdata", rsp_data, 0);
        chk("wr_resp_busy", cmd_ready, 0);
        step();
        chk("wr_ready_again", cmd_ready, 1);

        // read with 2 wait cycles in address phase and 3 in data phase
        hr_sched = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        nonseq = 0;
        HREADY = 1'b0;
        HRDATA = 32'h1234_5678;
        send(2'b10, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            HREADY = hr_sched[k];
            if (HTRANS == 2'b10) nonseq++;
            chk("wait_no_rsp", rsp_valid, 0);
            if (k <= 3) begin
                chk("wait_haddr", HADDR, 32'h2000_0014);
                chk("wait_hwrite", HWRITE, 0);
                chk("wait_addr_htrans", HTRANS, 2'b10);
            end else begin
                chk("wait_data_htrans", HTRANS, 2'b00);
            end
            step();
        end
        chk("wait_rvalid", rsp_valid, 1);
        chk("wait_rdata", rsp_data, 32'h1234_5678);
        chk("wait_err", rsp_err, 0);
        chk("wait_nonseq_cycles", nonseq, 3);
        HREADY = 1'b1;
        step();

        // error response on a write: no increment afterwards
        send(2'b01, 32'hCAFE_0000);
        chk("err_haddr", HADDR, 32'h2000_0018);
        step();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        chk("err_htrans1", HTRANS, 2'b00);
        step();
        HREADY = 1'b1;
        chk("err_htrans2", HTRANS, 2'b00);
        chk("err_no_rsp", rsp_valid, 0);
        step();
        HRESP = 1'b0;
        chk("err_rvalid", rsp_valid, 1);
        chk("err_rerr", rsp_err, 1);
        step();
        read_ok("err_noinc", 32'h2000_0018, 32'h0BAD_F00D);

        // alignment and wrap
        send(2'b00, 32'hFFFF_FFFF);
        chk("wrap_seta_rdata", rsp_data, 32'hFFFF_FFFF);
        step();
        read_ok("wrap_align", 32'hFFFF_FFFC, 32'hA5A5_5A5A);
        read_ok("wrap_zero", 32'h0000_0000, 32'h1111_2222);

        // reserved op
        send(2'b11, 32'h0000_1234);
        chk("rsv_rvalid", rsp_valid, 1);
        chk("rsv_err", rsp_err, 1);
        chk("rsv_rdata", rsp_data, 0);
        chk("rsv_htrans", HTRANS, 2'b00);
        step();
        chk("rsv_htrans_after", HTRANS, 2'b00);

        // command held pending while a read is in flight
        HREADY = 1'b0;
        HRDATA = 32'h7777_8888;
        send(2'b10, 32'h0);
        chk("bp_haddr", HADDR, 32'h0000_0004);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 32'h0000_0040;
        chk("bp_ready_addr", cmd_ready, 0);
        step();
        HREADY = 1'b1;
        chk("bp_ready_addr2", cmd_ready, 0);
        step();
        chk("bp_ready_data", cmd_ready, 0);
        chk("bp_htrans_data", HTRANS, 2'b00);
        step();
        chk("bp_rdata", rsp_data, 32'h7777_8888);
        chk("bp_ready_resp", cmd_ready, 0);
        step();
        chk("bp_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("bp_pending_rvalid", rsp_valid, 1);
        chk("bp_pending_rdata", rsp_data, 32'h0000_0040);
        step();

        // reset during the data phase
        HREADY = 1'b1;
        send(2'b01, 32'h1357_9BDF);
        step();
        chk("rr_in_data", HWDATA, 32'h1357_9BDF);
        HREADY = 1'b0;
        HRESET = 1'b1;
        step();
        chk("rr_rvalid", rsp_valid, 0);
        chk("rr_htrans", HTRANS, 2'b00);
        chk("rr_haddr", HADDR, 0);
        chk("rr_hwrite", HWRITE, 0);
        chk("rr_hwdata", HWDATA, 0);
        chk("rr_rsp", {rsp_err, rsp_data}, 0);
        HRESET = 1'b0;
        HREADY = 1'b1;
        step();
        chk("rr_no_late_rsp", rsp_valid, 0);
        read_ok("rr_read0", 32'h0000_0000, 32'h2468_ACE0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
